// File: rtl/game_pkg.sv
// Shared types and default sprite hitbox sizes for the chase-game round logic.
package game_pkg;

    typedef enum logic [1:0] {
        GO_RUN    = 2'b00,
        GO_JERRY  = 2'b01,
        GO_CAUGHT = 2'b10,
        GO_TIMEUP = 2'b11
    } gameover_t;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_OVER = 1'b1
    } round_state_t;

    localparam int unsigned DEF_CATCHER_W = 30;
    localparam int unsigned DEF_CATCHER_H = 50;
    localparam int unsigned DEF_JERRY_W   = 24;
    localparam int unsigned DEF_JERRY_H   = 18;

endpackage

// File: rtl/game_end_ctrl_hitbox_overlap.sv
// Combinational overlap test between a shrunken catcher box (a) and Jerry's box (b).
module hitbox_overlap #(
    parameter int unsigned POS_W  = 11,
    parameter int unsigned A_W    = 30,
    parameter int unsigned A_H    = 50,
    parameter int unsigned MARGIN = 4,
    parameter int unsigned B_W    = 24,
    parameter int unsigned B_H    = 18
) (
    input  logic [POS_W-1:0] i_a_x,
    input  logic [POS_W-1:0] i_a_y,
    input  logic [POS_W-1:0] i_b_x,
    input  logic [POS_W-1:0] i_b_y,
    output logic             o_hit_c
);

    localparam int unsigned EW = POS_W + 2;

    logic [EW-1:0] w_ax0, w_ax1, w_ay0, w_ay1;
    logic [EW-1:0] w_bx0, w_bx1, w_by0, w_by1;

    // Two guard bits keep the far edges from wrapping near the top of the range.
    assign w_ax0 = EW'(i_a_x) + EW'(MARGIN);
    assign w_ax1 = EW'(i_a_x) + EW'(A_W - MARGIN);
    assign w_ay0 = EW'(i_a_y) + EW'(MARGIN);
    assign w_ay1 = EW'(i_a_y) + EW'(A_H - MARGIN);
    assign w_bx0 = EW'(i_b_x);
    assign w_bx1 = EW'(i_b_x) + EW'(B_W);
    assign w_by0 = EW'(i_b_y);
    assign w_by1 = EW'(i_b_y) + EW'(B_H);

    // Strict compares: touching edges do not count.
    assign o_hit_c = (w_ax0 < w_bx1) && (w_bx0 < w_ax1) &&
                     (w_ay0 < w_by1) && (w_by0 < w_ay1);

endmodule

// File: rtl/game_end_ctrl.sv
// Round-end controller: confirms catches over consecutive frames, handles cheese and timeout.
module game_end_ctrl
    import game_pkg::*;
#(
    parameter int unsigned N_CATCHERS     = 1,
    parameter int unsigned POS_W          = 11,
    parameter int unsigned CATCHER_W      = DEF_CATCHER_W,
    parameter int unsigned CATCHER_H      = DEF_CATCHER_H,
    parameter int unsigned JERRY_W        = DEF_JERRY_W,
    parameter int unsigned JERRY_H        = DEF_JERRY_H,
    parameter int unsigned MARGIN         = 4,
    parameter int unsigned CONFIRM_FRAMES = 2,
    parameter int unsigned TIMEOUT_FRAMES = 0,
    localparam int unsigned WID_W = (N_CATCHERS > 1) ? $clog2(N_CATCHERS) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          frame_tick,
    input  logic                          restart,
    input  logic                          cheese_done,
    input  logic [N_CATCHERS*POS_W-1:0]   catcher_x,
    input  logic [N_CATCHERS*POS_W-1:0]   catcher_y,
    input  logic [POS_W-1:0]              jerry_x,
    input  logic [POS_W-1:0]              jerry_y,
    output logic [1:0]                    gameover,
    output logic [WID_W-1:0]              winner_id,
    output logic [31:0]                   frames_left
);

    localparam int unsigned CNT_W = (CONFIRM_FRAMES > 1) ? $clog2(CONFIRM_FRAMES + 1) : 1;

    round_state_t     r_state, w_state_nxt;
    gameover_t        r_gameover, w_gameover_nxt;
    logic [WID_W-1:0] r_winner, w_winner_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [31:0]      r_frames_left, w_frames_left_nxt;

    logic [N_CATCHERS-1:0] w_hit;
    logic                  w_any_hit;
    logic                  w_caught;
    logic [WID_W-1:0]      w_first_hit;

    for (genvar g = 0; g < int'(N_CATCHERS); g++) begin : g_hit
        hitbox_overlap #(
            .POS_W (POS_W),
            .A_W   (CATCHER_W),
            .A_H   (CATCHER_H),
            .MARGIN(MARGIN),
            .B_W   (JERRY_W),
            .B_H   (JERRY_H)
        ) u_hit (
            .i_a_x  (catcher_x[g*POS_W +: POS_W]),
            .i_a_y  (catcher_y[g*POS_W +: POS_W]),
            .i_b_x  (jerry_x),
            .i_b_y  (jerry_y),
            .o_hit_c(w_hit[g])
        );
    end

    assign w_any_hit = |w_hit;
    assign w_caught  = w_any_hit && ((32'(r_cnt) + 32'd1) >= 32'(CONFIRM_FRAMES));

    // Downward scan so the lowest overlapping index is the one left standing.
    always_comb begin
        w_first_hit = '0;
        for (int i = int'(N_CATCHERS) - 1; i >= 0; i--) begin
            if (w_hit[i]) w_first_hit = WID_W'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_RUN;
            r_gameover    <= GO_RUN;
            r_winner      <= '0;
            r_cnt         <= '0;
            r_frames_left <= 32'(TIMEOUT_FRAMES);
        end else begin
            r_state       <= w_state_nxt;
            r_gameover    <= w_gameover_nxt;
            r_winner      <= w_winner_nxt;
            r_cnt         <= w_cnt_nxt;
            r_frames_left <= w_frames_left_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_gameover_nxt    = r_gameover;
        w_winner_nxt      = r_winner;
        w_cnt_nxt         = r_cnt;
        w_frames_left_nxt = r_frames_left;

        // restart beats any coincident frame_tick, in either state.
        if (restart) begin
            w_state_nxt       = ST_RUN;
            w_gameover_nxt    = GO_RUN;
            w_winner_nxt      = '0;
            w_cnt_nxt         = '0;
            w_frames_left_nxt = 32'(TIMEOUT_FRAMES);
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (frame_tick) begin
                        if (!w_any_hit)
                            w_cnt_nxt = '0;
                        else if (32'(r_cnt) < 32'(CONFIRM_FRAMES))
                            w_cnt_nxt = r_cnt + CNT_W'(1);

                        if (w_caught) begin
                            w_gameover_nxt = GO_CAUGHT;
                            w_winner_nxt   = w_first_hit;
                            w_state_nxt    = ST_OVER;
                        end else if (cheese_done) begin
                            w_gameover_nxt = GO_JERRY;
                            w_state_nxt    = ST_OVER;
                        end else if ((TIMEOUT_FRAMES != 0) && (r_frames_left != 32'd0)) begin
                            w_frames_left_nxt = r_frames_left - 32'd1;
                            if (r_frames_left == 32'd1) begin
                                w_gameover_nxt = GO_TIMEUP;
                                w_state_nxt    = ST_OVER;
                            end
                        end
                    end
                end
                ST_OVER: begin
                end
                default: begin
                    w_state_nxt = ST_RUN;
                end
            endcase
        end
    end

    assign gameover    = r_gameover;
    assign winner_id   = r_winner;
    assign frames_left = r_frames_left;

endmodule

// File: tb/tb_game_end_ctrl.sv
// Directed bench: one single-catcher instance (no timeout) and one three-catcher instance (timeout 5).
`timescale 1ns/1ps
module tb_game_end_ctrl;

    localparam int unsigned POS_W = 11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [POS_W-1:0] jerry_x = 11'd100;
    logic [POS_W-1:0] jerry_y = 11'd100;

    logic             a_tick = 1'b0, a_restart = 1'b0, a_cheese = 1'b0;
    logic [POS_W-1:0] a_cx = 11'd500, a_cy = 11'd500;
    logic [1:0]       a_go;
    logic [0:0]       a_win;
    logic [31:0]      a_fl;

    logic             b_tick = 1'b0, b_restart = 1'b0, b_cheese = 1'b0;
    logic [3*POS_W-1:0] b_cx = {3{11'd500}}, b_cy = {3{11'd500}};
    logic [1:0]       b_go;
    logic [1:0]       b_win;
    logic [31:0]      b_fl;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    game_end_ctrl #(.N_CATCHERS(1), .CONFIRM_FRAMES(2), .TIMEOUT_FRAMES(0)) u_a (
        .clk(clk), .rst(rst), .frame_tick(a_tick), .restart(a_restart), .cheese_done(a_cheese),
        .catcher_x(a_cx), .catcher_y(a_cy), .jerry_x(jerry_x), .jerry_y(jerry_y),
        .gameover(a_go), .winner_id(a_win), .frames_left(a_fl)
    );

    game_end_ctrl #(.N_CATCHERS(3), .CONFIRM_FRAMES(2), .TIMEOUT_FRAMES(5)) u_b (
        .clk(clk), .rst(rst), .frame_tick(b_tick), .restart(b_restart), .cheese_done(b_cheese),
        .catcher_x(b_cx), .catcher_y(b_cy), .jerry_x(jerry_x), .jerry_y(jerry_y),
        .gameover(b_go), .winner_id(b_win), .frames_left(b_fl)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick_a(input logic cheese);
        @(negedge clk); a_tick = 1'b1; a_cheese = cheese;
        @(negedge clk); a_tick = 1'b0; a_cheese = 1'b0;
    endtask

    task automatic tick_b(input logic cheese);
        @(negedge clk); b_tick = 1'b1; b_cheese = cheese;
        @(negedge clk); b_tick = 1'b0; b_cheese = 1'b0;
    endtask

    task automatic restart_a();
        @(negedge clk); a_restart = 1'b1;
        @(negedge clk); a_restart = 1'b0;
    endtask

    task automatic restart_b();
        @(negedge clk); b_restart = 1'b1;
        @(negedge clk); b_restart = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;

        check("a_reset_go", 32'(a_go), 32'd0);
        check("a_reset_win", 32'(a_win), 32'd0);
        check("a_reset_fl", a_fl, 32'd0);
        check("b_reset_fl", b_fl, 32'd5);

        // catcher (90,80) overlaps Jerry (100,100)
        a_cx = 11'd90; a_cy = 11'd80;
        tick_a(1'b0);
        check("a_one_tick", 32'(a_go), 32'd0);
        a_cx = 11'd500;
        tick_a(1'b0);
        a_cx = 11'd90;
        tick_a(1'b0);
        check("a_broken_streak", 32'(a_go), 32'd0);
        tick_a(1'b0);
        check("a_caught", 32'(a_go), 32'd2);
        check("a_caught_win", 32'(a_win), 32'd0);

        a_cx = 11'd500;
        tick_a(1'b1);
        tick_a(1'b0);
        check("a_over_frozen", 32'(a_go), 32'd2);
        restart_a();
        check("a_restart_go", 32'(a_go), 32'd0);

        // right catcher edge touching Jerry's left edge
        a_cx = 11'd74; a_cy = 11'd80;
        repeat (5) tick_a(1'b0);
        check("a_touch_left", 32'(a_go), 32'd0);
        // left catcher edge touching Jerry's right edge
        a_cx = 11'd120;
        repeat (3) tick_a(1'b0);
        check("a_touch_right", 32'(a_go), 32'd0);
        a_cx = 11'd119;
        repeat (2) tick_a(1'b0);
        check("a_one_px_overlap", 32'(a_go), 32'd2);
        restart_a();

        a_cx = 11'd500;
        tick_a(1'b1);
        check("a_cheese", 32'(a_go), 32'd1);
        restart_a();

        a_cx = 11'd90;
        tick_a(1'b0);
        tick_a(1'b1);
        check("a_catch_beats_cheese", 32'(a_go), 32'd2);
        restart_a();

        // restart coincident with the confirming tick discards it and clears the streak
        tick_a(1'b0);
        @(negedge clk); a_tick = 1'b1; a_restart = 1'b1;
        @(negedge clk); a_tick = 1'b0; a_restart = 1'b0;
        check("a_restart_wins", 32'(a_go), 32'd0);
        tick_a(1'b0);
        check("a_streak_cleared", 32'(a_go), 32'd0);
        tick_a(1'b0);
        check("a_recatch", 32'(a_go), 32'd2);

        @(negedge clk); rst = 1'b1; a_restart = 1'b1;
        @(negedge clk); rst = 1'b0; a_restart = 1'b0;
        check("a_rst_over_go", 32'(a_go), 32'd0);
        check("a_rst_over_win", 32'(a_win), 32'd0);

        // rst mid-streak clears the confirm counter
        tick_a(1'b0);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        tick_a(1'b0);
        check("a_rst_clears_cnt", 32'(a_go), 32'd0);

        // instance B: catchers 1 and 2 overlap, catcher 0 far away
        b_cx = {11'd95, 11'd90, 11'd500};
        b_cy = {11'd85, 11'd80, 11'd500};
        tick_b(1'b0);
        check("b_first_tick_fl", b_fl, 32'd4);
        tick_b(1'b0);
        check("b_caught", 32'(b_go), 32'd2);
        check("b_lowest_win", 32'(b_win), 32'd1);
        check("b_caught_fl", b_fl, 32'd4);
        restart_b();
        check("b_restart_go", 32'(b_go), 32'd0);
        check("b_restart_fl", b_fl, 32'd5);
        check("b_restart_win", 32'(b_win), 32'd0);

        b_cx = {11'd95, 11'd500, 11'd500};
        b_cy = {11'd85, 11'd500, 11'd500};
        repeat (2) tick_b(1'b0);
        check("b_win2", 32'(b_win), 32'd2);
        restart_b();

        b_cx = {3{11'd500}};
        repeat (4) tick_b(1'b0);
        check("b_fl_1", b_fl, 32'd1);
        check("b_not_yet", 32'(b_go), 32'd0);
        tick_b(1'b0);
        check("b_timeup", 32'(b_go), 32'd3);
        check("b_timeup_fl", b_fl, 32'd0);
        tick_b(1'b1);
        tick_b(1'b0);
        check("b_timeup_frozen", 32'(b_go), 32'd3);
        check("b_timeup_fl_frozen", b_fl, 32'd0);
        restart_b();
        check("b_restart2_go", 32'(b_go), 32'd0);
        check("b_restart2_fl", b_fl, 32'd5);

        tick_b(1'b0);
        restart_b();
        check("b_restart_run_fl", b_fl, 32'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/game_end_ctrl.md
Name: game_end_ctrl

Overview:
- Parametrised round-end controller for the chase game.
- Evaluates hitbox overlap between Jerry and N_CATCHERS Tom-type sprites once per frame.
- Requires a catch to persist CONFIRM_FRAMES consecutive frames before declaring it; also accepts a cheese-complete event and an optional round timeout.
- Latches the result until restart; output feeds the screen-select/overlay logic.

Parameters:
- N_CATCHERS, 1, number of catcher sprites checked (1..4)
- POS_W, 11, width of x/y position fields
- CATCHER_W, 30, catcher hitbox width (px)
- CATCHER_H, 50, catcher hitbox height (px)
- JERRY_W, 24, Jerry hitbox width (px)
- JERRY_H, 18, Jerry hitbox height (px)
- MARGIN, 4, px shaved from every catcher hitbox edge; must be < CATCHER_W/2 and < CATCHER_H/2
- CONFIRM_FRAMES, 2, consecutive overlapping frames needed for a catch (>=1)
- TIMEOUT_FRAMES, 0, frames until time-up; 0 disables

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- frame_tick  in  1  one-cycle pulse per frame; positions are stable on this cycle
- restart  in  1  one-cycle pulse; leaves OVER and starts a new round
- cheese_done  in  1  level; all cheese collected
- catcher_x  in  N_CATCHERS*POS_W  packed catcher top-left x, index 0 in LSBs
- catcher_y  in  N_CATCHERS*POS_W  packed catcher top-left y
- jerry_x  in  POS_W  Jerry top-left x
- jerry_y  in  POS_W  Jerry top-left y
- gameover  out  2  00 running, 01 Jerry won (cheese), 10 caught, 11 time up
- winner_id  out  max(1,$clog2(N_CATCHERS))  index of the catching sprite, valid when gameover==10
- frames_left  out  32  remaining frames; 0 when the timeout is disabled

Behaviour:
- Reset: state RUN, gameover=00, winner_id=0, confirm counter 0, frames_left=TIMEOUT_FRAMES.
- Overlap for catcher i uses POS_W+2-bit unsigned arithmetic, with no wrap:
  - cx0=x+MARGIN, cx1=x+CATCHER_W-MARGIN (same form for y).
  - hit_i = (cx0 < jx+JERRY_W) && (jx < cx1) && (cy0 < jy+JERRY_H) && (jy < cy1).
  - Edges that only touch are not a hit.
- any_hit = OR of all hit_i. first_hit = lowest index i with hit_i=1.
- All evaluation happens only on cycles with frame_tick=1. Inputs on other cycles are ignored, except restart.
- RUN state:
  - On frame_tick with any_hit: confirm counter increments, saturating at CONFIRM_FRAMES. Without any_hit: counter clears to 0.
  - Caught = any_hit && (counter+1 >= CONFIRM_FRAMES).
  - Priority on the same tick: caught > cheese_done > timeout.
  - Caught: gameover<=10, winner_id<=first_hit, go to OVER.
  - Else cheese_done: gameover<=01, go to OVER.
  - Else, if TIMEOUT_FRAMES!=0: frames_left decrements. When it goes 1->0: gameover<=11, go to OVER.
- OVER state:
  - Outputs, winner_id and frames_left are frozen. frame_tick, cheese_done and positions are ignored.
  - restart: go to RUN; counter=0, frames_left=TIMEOUT_FRAMES, gameover=00, winner_id=0, all on the next edge.
- restart in RUN restarts the round with the same clears. If frame_tick arrives in the same cycle, restart wins and that tick is discarded.
- Latency: gameover changes on the clock edge that samples the deciding frame_tick (registered, 1 cycle).
- rst mid-round or in OVER returns to the reset state on the next edge and overrides restart.

Decomposition:
- game_pkg gets:
  - typedef enum logic[1:0] {GO_RUN=2'b00, GO_JERRY=2'b01, GO_CAUGHT=2'b10, GO_TIMEUP=2'b11} gameover_t
  - the default hitbox constants CATCHER_W/H and JERRY_W/H
- Sub-module hitbox_overlap: purely combinational, one rectangle pair, generic widths. Instantiated N_CATCHERS times via generate.

Test Plan:
- Jerry (100,100), catcher0 (90,80), CONFIRM_FRAMES=2: two consecutive ticks -> gameover=10, winner_id=0 after the 2nd tick. A single tick followed by a non-overlap tick -> stays 00.
- Catcher placed so cx1 == jerry_x (edge touch), 5 ticks -> gameover stays 00.
- N_CATCHERS=3, catchers 1 and 2 both overlapping for 2 ticks -> gameover=10, winner_id=1.
- cheese_done=1 on the same tick as the confirming catch -> gameover=10. cheese_done alone -> 01.
- TIMEOUT_FRAMES=5, no hits -> gameover=11 on the 5th tick, frames_left=0. Further ticks and cheese_done -> no change.
- In OVER, restart -> next cycle gameover=00, frames_left=5. rst asserted in OVER with restart high -> reset values. restart coincident with a confirming tick in RUN -> stays 00.
